// File: rtl/reg_file_pkg.sv
// Shared widths, depth and the pending-write entry type for the register-file write side.
package reg_file_pkg;

   localparam int unsigned REG_W   = 16;
   localparam int unsigned REG_CNT = 16;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned DEPTH   = 2;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [REG_W-1:0]  data;
   } wr_entry_t;

endpackage

// File: rtl/reg_file_writer_if.sv
// Write-request handshake bundle: requester drives valid/addr/data, register file returns ready.
interface reg_file_writer_if;
   import reg_file_pkg::*;

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [REG_W-1:0]  wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/write_decoder_4to16.sv
// One-hot load-enable decoder for the commit path: exactly one bit set when en is high.
module write_decoder_4to16
   import reg_file_pkg::*;
(
   input  logic [ADDR_W-1:0]  addr,
   input  logic               en,
   output logic [REG_CNT-1:0] load
);

   always_comb begin
      load = '0;
      if (en) load[addr] = 1'b1;
   end

endmodule

// File: rtl/reg_file_writer.sv
// Write side of the 16 x 16-bit register file: 2-entry in-order write buffer, one commit per cycle.
// Optional REG_R0_ZERO_EN: r0 hardwired to zero; writes to address 0 are accepted and popped but dropped.
module reg_file_writer
   import reg_file_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   reg_file_writer_if.slave   wr,
   input  logic               commit_hold,
   output logic               pending,
   output logic [REG_W-1:0]   r0,
   output logic [REG_W-1:0]   r1,
   output logic [REG_W-1:0]   r2,
   output logic [REG_W-1:0]   r3,
   output logic [REG_W-1:0]   r4,
   output logic [REG_W-1:0]   r5,
   output logic [REG_W-1:0]   r6,
   output logic [REG_W-1:0]   r7,
   output logic [REG_W-1:0]   r8,
   output logic [REG_W-1:0]   r9,
   output logic [REG_W-1:0]   r10,
   output logic [REG_W-1:0]   r11,
   output logic [REG_W-1:0]   r12,
   output logic [REG_W-1:0]   r13,
   output logic [REG_W-1:0]   r14,
   output logic [REG_W-1:0]   r15
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   wr_entry_t          buf_q [DEPTH];
   logic               head, tail;
   logic [1:0]         count;
   logic [REG_W-1:0]   regs [REG_CNT];
   logic [REG_CNT-1:0] load, load_eff;
   logic               push, pop;
   wr_entry_t          head_entry;

   assign wr.wr_ready = (count < FULL) && !reset;
   assign push        = wr.wr_valid && wr.wr_ready;
   assign pop         = (count != 2'd0) && !commit_hold;
   assign pending     = (count != 2'd0);
   assign head_entry  = buf_q[head];

   write_decoder_4to16 u_dec (
      .addr (head_entry.addr),
      .en   (pop),
      .load (load)
   );

`ifdef REG_R0_ZERO_EN
   // r0 never loads, so it keeps its reset value of zero forever.
   assign load_eff = load & ~REG_CNT'(1);
`else
   assign load_eff = load;
`endif

   always_ff @(posedge clk) begin
      if (push) buf_q[tail] <= '{addr: wr.wr_addr, data: wr.wr_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
         for (int unsigned i = 0; i < REG_CNT; i++) regs[i] <= '0;
      end else begin
         if (push) tail <= ~tail;
         if (pop)  head <= ~head;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         for (int unsigned i = 0; i < REG_CNT; i++)
            if (load_eff[i]) regs[i] <= head_entry.data;
      end
   end

   assign r0  = regs[0];
   assign r1  = regs[1];
   assign r2  = regs[2];
   assign r3  = regs[3];
   assign r4  = regs[4];
   assign r5  = regs[5];
   assign r6  = regs[6];
   assign r7  = regs[7];
   assign r8  = regs[8];
   assign r9  = regs[9];
   assign r10 = regs[10];
   assign r11 = regs[11];
   assign r12 = regs[12];
   assign r13 = regs[13];
   assign r14 = regs[14];
   assign r15 = regs[15];

endmodule
